// File: rtl/matriz_pkg.sv
// rtl/matriz_pkg.sv - opcodes, FSM states and signed range helper for the matrix ALU
package matriz_pkg;
    localparam logic [3:0] OP_SOMA    = 4'b0011;
    localparam logic [3:0] OP_SUB     = 4'b0100;
    localparam logic [3:0] OP_MULT    = 4'b0101;
    localparam logic [3:0] OP_TRANSP  = 4'b0110;
    localparam logic [3:0] OP_OPOSTA  = 4'b0111;
    localparam logic [3:0] OP_ESCALAR = 4'b1000;

    // Wide enough for the largest product accumulator (2*16 + 3 bits)
    localparam int FW = 40;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic fits_w(input logic signed [FW-1:0] value, input int w);
        logic signed [FW-1:0] lim;
        lim = FW'(1) <<< (w - 1);
        return (value >= -lim) && (value < lim);
    endfunction
endpackage

// File: rtl/matriz_mac.sv
// rtl/matriz_mac.sv - signed multiply-accumulate shared by matrix product and scalar multiply
module matriz_mac #(
    parameter int W  = 8,
    parameter int AW = 2*W + 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [W-1:0]  a,
    input  logic signed [W-1:0]  b,
    output logic signed [AW-1:0] sum
);
    logic signed [AW-1:0]  acc_q;
    logic signed [2*W-1:0] prod;

    // sum already includes this cycle's product so the last MAC step can be written directly
    assign prod = (2*W)'(a) * (2*W)'(b);
    assign sum  = acc_q + AW'(prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc_q <= '0;
        else if (clr)
            acc_q <= '0;
        else if (en)
            acc_q <= sum;
    end
endmodule

// File: rtl/matriz_alu_seq.sv
// rtl/matriz_alu_seq.sv - sequential N x N matrix ALU, one result element (or one MAC) per cycle
module matriz_alu_seq
    import matriz_pkg::*;
#(
    parameter int N = 5,
    parameter int W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         opcode,
    input  logic [W-1:0]       data_escalar,
    input  logic [N*N*W-1:0]   matrizA,
    input  logic [N*N*W-1:0]   matrizB,
    output logic [N*N*W-1:0]   matriz_resultante,
    output logic               done,
    output logic               busy,
    output logic               overflow,
    output logic               err
);
    localparam int IW = $clog2(N);
    localparam int KW = $clog2(N*N);
    localparam int AW = 2*W + $clog2(N);
    localparam logic [IW-1:0] I_LAST = IW'(N-1);
    localparam logic [KW-1:0] K_LAST = KW'(N*N-1);

    state_t               state_q, state_d;
    logic [3:0]           op_q;
    logic signed [W-1:0]  esc_q;
    logic [N*N*W-1:0]     a_q, b_q;
    logic [IW-1:0]        r_q, c_q, m_q;
    logic [KW-1:0]        k_q;
    logic                 legal, write_el, mac_clr, mac_en;
    logic signed [W-1:0]  ea, eb, et, mac_a, mac_b;
    logic signed [AW-1:0] mac_sum;
    logic signed [FW-1:0] exact;

    function automatic int lin(input logic [IW-1:0] row, input logic [IW-1:0] col);
        return (int'(row) * N + int'(col)) * W;
    endfunction

    assign legal    = op_q inside {OP_SOMA, OP_SUB, OP_MULT, OP_TRANSP, OP_OPOSTA, OP_ESCALAR};
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign write_el = (state_q == RUN) && legal && ((op_q != OP_MULT) || (m_q == I_LAST));
    // Scalar multiply keeps the accumulator cleared so sum is just the product
    assign mac_en   = (state_q == RUN) && (op_q == OP_MULT);
    assign mac_clr  = !mac_en || (m_q == I_LAST);

    matriz_mac #(.W(W), .AW(AW)) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (mac_a),
        .b   (mac_b),
        .sum (mac_sum)
    );

    always_comb begin
        ea = a_q[lin(r_q, c_q) +: W];
        eb = b_q[lin(r_q, c_q) +: W];
        et = a_q[lin(c_q, r_q) +: W];
        if (op_q == OP_MULT) begin
            mac_a = a_q[lin(r_q, m_q) +: W];
            mac_b = b_q[lin(m_q, c_q) +: W];
        end else begin
            mac_a = ea;
            mac_b = esc_q;
        end
        case (op_q)
            OP_SOMA:             exact = FW'(ea) + FW'(eb);
            OP_SUB:              exact = FW'(ea) - FW'(eb);
            OP_TRANSP:           exact = FW'(et);
            OP_OPOSTA:           exact = -FW'(ea);
            OP_MULT, OP_ESCALAR: exact = FW'(mac_sum);
            default:             exact = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (!legal || (write_el && (k_q == K_LAST))) state_d = DONE;
            DONE:    if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q              <= '0;
            esc_q             <= '0;
            a_q               <= '0;
            b_q               <= '0;
            r_q               <= '0;
            c_q               <= '0;
            m_q               <= '0;
            k_q               <= '0;
            matriz_resultante <= '0;
            overflow          <= 1'b0;
            err               <= 1'b0;
        end else if ((state_q == IDLE) && start) begin
            op_q              <= opcode;
            esc_q             <= data_escalar;
            a_q               <= matrizA;
            b_q               <= matrizB;
            r_q               <= '0;
            c_q               <= '0;
            m_q               <= '0;
            k_q               <= '0;
            matriz_resultante <= '0;
            overflow          <= 1'b0;
            err               <= 1'b0;
        end else if (state_q == RUN) begin
            if (!legal)
                err <= 1'b1;
            if (mac_en)
                m_q <= (m_q == I_LAST) ? '0 : m_q + 1'b1;
            if (write_el) begin
                matriz_resultante[lin(r_q, c_q) +: W] <= exact[W-1:0];
                if (!fits_w(exact, W))
                    overflow <= 1'b1;
                k_q <= k_q + 1'b1;
                if (c_q == I_LAST) begin
                    c_q <= '0;
                    r_q <= r_q + 1'b1;
                end else begin
                    c_q <= c_q + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_matriz_alu_seq.sv
// tb/tb_matriz_alu_seq.sv - randomized self-checking bench for matriz_alu_seq
module tb_matriz_alu_seq;
    localparam int N  = 5;
    localparam int W  = 8;
    localparam int MW = N*N*W;
    typedef logic [MW-1:0] mat_t;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [3:0]   opcode;
    logic [W-1:0] data_escalar;
    mat_t         matrizA, matrizB, matriz_resultante;
    logic         done, busy, overflow, err;

    int   checks = 0;
    int   errors = 0;
    mat_t exp_res;
    logic exp_ovf, exp_err;
    int   exp_lat;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    matriz_alu_seq #(.N(N), .W(W)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .opcode            (opcode),
        .data_escalar      (data_escalar),
        .matrizA           (matrizA),
        .matrizB           (matrizB),
        .matriz_resultante (matriz_resultante),
        .done              (done),
        .busy              (busy),
        .overflow          (overflow),
        .err               (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input mat_t act, input mat_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int el(input mat_t m, input int r, input int c);
        logic signed [W-1:0] v;
        v = m[(r*N+c)*W +: W];
        return int'(v);
    endfunction

    function automatic mat_t fill(input int v);
        mat_t m;
        for (int i = 0; i < N*N; i++) m[i*W +: W] = v[W-1:0];
        return m;
    endfunction

    function automatic mat_t seq_mat();
        mat_t m;
        for (int i = 0; i < N*N; i++) m[i*W +: W] = W'(i);
        return m;
    endfunction

    function automatic mat_t ident();
        mat_t m;
        m = '0;
        for (int i = 0; i < N; i++) m[(i*N+i)*W +: W] = W'(1);
        return m;
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int i = 0; i < N*N; i++) m[i*W +: W] = W'($urandom);
        return m;
    endfunction

    // Reference: exact integer result per element, wrapped to W bits
    task automatic model(input logic [3:0] op, input int esc, input mat_t a, input mat_t b);
        exp_err = !(op inside {4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8});
        exp_ovf = 1'b0;
        exp_res = '0;
        exp_lat = exp_err ? 1 : (op == 4'd5) ? N*N*N : N*N;
        if (!exp_err) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    int v;
                    v = 0;
                    case (op)
                        4'd3: v = el(a, r, c) + el(b, r, c);
                        4'd4: v = el(a, r, c) - el(b, r, c);
                        4'd5: for (int m = 0; m < N; m++) v += el(a, r, m) * el(b, m, c);
                        4'd6: v = el(a, c, r);
                        4'd7: v = -el(a, r, c);
                        default: v = esc * el(a, r, c);
                    endcase
                    if (v < -(1 << (W-1)) || v > (1 << (W-1)) - 1) exp_ovf = 1'b1;
                    exp_res[(r*N+c)*W +: W] = v[W-1:0];
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && done) begin
            chk_vec("result", matriz_resultante, exp_res);
            chk("overflow", overflow, exp_ovf);
            chk("err", err, exp_err);
            chk("busy_in_done", busy, 0);
        end
    end

    task automatic run_op(input logic [3:0] op, input int esc, input mat_t a, input mat_t b,
                          input bit drop, input bit poke);
        int cycles;
        model(op, esc, a, b);
        @(negedge clk);
        opcode       = op;
        data_escalar = esc[W-1:0];
        matrizA      = a;
        matrizB      = b;
        start        = 1'b1;
        @(posedge clk);
        cycles = 0;
        @(negedge clk);
        chk("busy_after_capture", busy, 1);
        if (drop) start = 1'b0;
        while (!done && cycles < 1000) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (poke && cycles == 3) begin
                matrizA      = rand_mat();
                matrizB      = rand_mat();
                opcode       = 4'($urandom);
                data_escalar = W'($urandom);
            end
        end
        chk("latency", cycles, exp_lat);
        if (!drop) begin
            repeat (3) begin
                @(negedge clk);
                chk("done_hold", done, 1);
            end
            start = 1'b0;
        end
        @(negedge clk);
        chk("done_clear", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        mat_t ta, tb;
        rst = 1'b1; start = 1'b0; opcode = '0; data_escalar = '0;
        matrizA = '0; matrizB = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_err", err, 0);
        chk_vec("rst_result", matriz_resultante, '0);
        rst = 1'b0;
        chk_en = 1'b1;

        run_op(4'b0011, 0, fill(3), fill(4), 1'b0, 1'b0);
        chk("sum_el0", matriz_resultante[0 +: W], 7);
        chk("sum_el24", matriz_resultante[24*W +: W], 7);
        chk("sum_ovf", overflow, 0);

        ta = '0; ta[0 +: W] = 8'h80;
        tb = '0; tb[0 +: W] = 8'h01;
        run_op(4'b0100, 0, ta, tb, 1'b0, 1'b0);
        chk("sub_el00", matriz_resultante[0 +: W], 8'h7F);
        chk("sub_ovf", overflow, 1);
        chk_vec("sub_rest", matriz_resultante >> W, '0);

        run_op(4'b0101, 0, ident(), seq_mat(), 1'b0, 1'b0);
        chk_vec("prod_ident", matriz_resultante, seq_mat());
        run_op(4'b0101, 0, fill(2), fill(2), 1'b0, 1'b0);
        chk("prod_twos", matriz_resultante[7*W +: W], 20);

        run_op(4'b0110, 0, seq_mat(), '0, 1'b0, 1'b0);
        chk("transp_10", matriz_resultante[5*W +: W], 1);
        chk("transp_01", matriz_resultante[1*W +: W], 5);

        run_op(4'b0111, 0, fill(-128), '0, 1'b0, 1'b0);
        chk("neg_ovf", overflow, 1);
        chk("neg_el0", matriz_resultante[0 +: W], 8'h80);

        run_op(4'b1000, -3, fill(5), '0, 1'b0, 1'b0);
        chk("esc_el12", matriz_resultante[12*W +: W], 8'hF1);

        run_op(4'b1111, 0, rand_mat(), rand_mat(), 1'b0, 1'b0);
        chk("illegal_err", err, 1);
        chk_vec("illegal_result", matriz_resultante, '0);

        @(negedge clk);
        opcode = 4'b0101; matrizA = rand_mat(); matrizB = rand_mat(); start = 1'b1;
        @(posedge clk);
        repeat (60) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ovf", overflow, 0);
        chk_vec("midrst_result", matriz_resultante, '0);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;

        run_op(4'b0101, 0, rand_mat(), rand_mat(), 1'b1, 1'b1);
        run_op(4'b0011, 0, rand_mat(), rand_mat(), 1'b1, 1'b1);

        for (int i = 0; i < 14; i++) begin
            logic [3:0] op;
            if ($urandom_range(0, 7) == 0) op = 4'($urandom);
            else op = 4'($urandom_range(3, 8));
            run_op(op, int'($urandom_range(0, 255)) - 128, rand_mat(), rand_mat(),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
